// File: rtl/uart_rx.sv
// UART receiver: oversamples RX_IN with a runtime prescale, qualifies the
// start bit, deserialises OP_WIDTH data bits LSB-first, optionally checks a
// parity bit, checks the stop bit and strobes the received word out.
// Optional feature macro: UART_RX_ERR_CNT_EN adds a saturating 8-bit count
// of frames that ended in a parity and/or stop-bit error (port err_cnt).
module uart_rx #(
    parameter int OP_WIDTH   = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [OP_WIDTH-1:0]   P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  rx_busy
`ifdef UART_RX_ERR_CNT_EN
    ,
    output logic [7:0]            err_cnt
`endif
);

    localparam int BIT_W = (OP_WIDTH > 1) ? $clog2(OP_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [PRESCALE_W-1:0] presc_q;
    logic [PRESCALE_W-1:0] last_cnt;
    logic [PRESCALE_W-1:0] mid_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_fail;
    logic [OP_WIDTH-1:0]   shift_reg;
    logic [2:0]            samples;
    logic                  majority;
    logic                  bit_end;
    logic                  frame_end;
    logic                  frame_par_bad;
    logic                  frame_stp_bad;

    // The latched prescale fixes both the wrap point and the centre of each bit.
    // A degenerate prescale (0 or 1) just makes the counter wrap at its natural
    // overflow, so the FSM always keeps moving.
    assign last_cnt = presc_q - PRESCALE_W'(1);
    assign mid_cnt  = presc_q >> 1;
    assign bit_end  = (edge_cnt == last_cnt);
    assign majority = (samples[0] & samples[1]) |
                      (samples[0] & samples[2]) |
                      (samples[1] & samples[2]);

    // Capture three samples around the middle of the bit for the 2-of-3 vote.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            samples <= '0;
        end else if (state != IDLE) begin
            if (edge_cnt == mid_cnt - PRESCALE_W'(1)) samples[0] <= RX_IN;
            if (edge_cnt == mid_cnt)                  samples[1] <= RX_IN;
            if (edge_cnt == mid_cnt + PRESCALE_W'(1)) samples[2] <= RX_IN;
        end
    end

    // Receive FSM with its bit timing, shift register and registered outcome
    // strobes; the outcome lands one cycle after the stop-bit decision so the
    // FSM itself is already back in IDLE and can accept the next start bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state         <= IDLE;
            edge_cnt      <= '0;
            bit_cnt       <= '0;
            presc_q       <= '0;
            par_en_q      <= 1'b0;
            par_typ_q     <= 1'b0;
            par_fail      <= 1'b0;
            shift_reg     <= '0;
            frame_end     <= 1'b0;
            frame_par_bad <= 1'b0;
            frame_stp_bad <= 1'b0;
            P_DATA        <= '0;
            data_valid    <= 1'b0;
            par_err       <= 1'b0;
            stp_err       <= 1'b0;
            rx_busy       <= 1'b0;
        end else begin
            frame_end  <= 1'b0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;

            if (frame_end) begin
                if (!frame_par_bad && !frame_stp_bad) begin
                    P_DATA     <= shift_reg;
                    data_valid <= 1'b1;
                end
                par_err <= frame_par_bad;
                stp_err <= frame_stp_bad;
            end

            if (state != IDLE) begin
                edge_cnt <= bit_end ? '0 : edge_cnt + PRESCALE_W'(1);
            end

            case (state)
                IDLE: begin
                    edge_cnt <= '0;
                    bit_cnt  <= '0;
                    if (!RX_IN) begin
                        state     <= START;
                        edge_cnt  <= PRESCALE_W'(1);
                        presc_q   <= Prescale;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        par_fail  <= 1'b0;
                        rx_busy   <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        if (majority) begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_reg <= {majority, shift_reg[OP_WIDTH-1:1]};
                        if (bit_cnt == BIT_W'(OP_WIDTH - 1)) begin
                            bit_cnt <= '0;
                            state   <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        par_fail <= (majority != ((^shift_reg) ^ par_typ_q));
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        frame_end     <= 1'b1;
                        frame_par_bad <= par_fail;
                        frame_stp_bad <= ~majority;
                        state         <= IDLE;
                        rx_busy       <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    // One increment per errored frame, saturating; only reset clears it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_cnt <= '0;
        end else if (frame_end && (frame_par_bad || frame_stp_bad) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized frames
// checked against a frame-level reference model and event scoreboard.
module tb_uart_rx;

    typedef struct {
        int         cyc;
        logic [2:0] kind;
        logic [7:0] data;
    } ev_t;

    logic       CLK      = 1'b0;
    logic       RST      = 1'b0;
    logic       RX_IN    = 1'b1;
    logic [5:0] Prescale = 6'd8;
    logic       PAR_EN   = 1'b0;
    logic       PAR_TYP  = 1'b0;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       rx_busy;
`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int         dv_cnt   = 0;
    int         pe_cnt   = 0;
    int         se_cnt   = 0;
    int         busy_cnt = 0;
    int         dv_cyc_q[$];
    logic [7:0] dv_data_q[$];
    ev_t        act_q[$];

    logic [7:0] model_data = 8'h00;
    int         model_err  = 0;

    uart_rx #(.OP_WIDTH(8), .PRESCALE_W(6)) dut (
        .CLK(CLK),
        .RST(RST),
        .RX_IN(RX_IN),
        .Prescale(Prescale),
        .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP),
        .P_DATA(P_DATA),
        .data_valid(data_valid),
        .par_err(par_err),
        .stp_err(stp_err),
        .rx_busy(rx_busy)
`ifdef UART_RX_ERR_CNT_EN
        ,
        .err_cnt(err_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Record every strobe on the falling edge, away from the active edge.
    always @(negedge CLK) begin
        if (data_valid) begin
            dv_cnt++;
            dv_cyc_q.push_back(cyc);
            dv_data_q.push_back(P_DATA);
        end
        if (par_err) pe_cnt++;
        if (stp_err) se_cnt++;
        if (rx_busy) busy_cnt++;
        if (data_valid || par_err || stp_err)
            act_q.push_back('{cyc, {data_valid, par_err, stp_err}, P_DATA});
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int pick_presc();
        case ($urandom_range(0, 2))
            0:       return 8;
            1:       return 16;
            default: return 32;
        endcase
    endfunction

    task automatic clear_monitor();
        dv_cnt   = 0;
        pe_cnt   = 0;
        se_cnt   = 0;
        busy_cnt = 0;
        dv_cyc_q.delete();
        dv_data_q.delete();
        act_q.delete();
    endtask

    // Drives one frame starting right after a falling edge; each bit is held
    // for presc cycles. Optionally scrambles the config inputs mid-frame.
    task automatic send_frame(input logic [7:0] data, input int presc, input bit pen,
                              input bit ptyp, input bit flip_par, input bit stop_val,
                              input bit scramble, output int start_cyc);
        Prescale  = 6'(presc);
        PAR_EN    = pen;
        PAR_TYP   = ptyp;
        RX_IN     = 1'b0;
        start_cyc = cyc;
        repeat (presc) @(negedge CLK);
        if (scramble) begin
            Prescale = 6'(pick_presc());
            PAR_EN   = 1'($urandom_range(0, 1));
            PAR_TYP  = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 8; i++) begin
            RX_IN = data[i];
            repeat (presc) @(negedge CLK);
        end
        if (pen) begin
            RX_IN = (^data) ^ ptyp ^ flip_par;
            repeat (presc) @(negedge CLK);
        end
        RX_IN = stop_val;
        repeat (presc) @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        checks++; if (P_DATA !== 8'h00) begin failures++; $display("[TB] FAIL reset_p_data: got %h expected 00", P_DATA); end
        checks++; if (data_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_data_valid: got %b expected 0", data_valid); end
        checks++; if (par_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_par_err: got %b expected 0", par_err); end
        checks++; if (stp_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_stp_err: got %b expected 0", stp_err); end
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_rx_busy: got %b expected 0", rx_busy); end
`ifdef UART_RX_ERR_CNT_EN
        checks++; if (err_cnt !== 8'd0) begin failures++; $display("[TB] FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
`endif
        RST = 1'b1;
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_parity_good();
        int s;
        clear_monitor();
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, s);
        RX_IN = 1'b1;
        repeat (6) @(negedge CLK);
        model_data = 8'hA5;
        checks++; if (dv_cnt != 1) begin failures++; $display("[TB] FAIL good_dv_count: got %0d expected 1", dv_cnt); end
        checks++; if (pe_cnt != 0 || se_cnt != 0) begin failures++; $display("[TB] FAIL good_no_err: got par %0d stp %0d expected 0 0", pe_cnt, se_cnt); end
        checks++; if (P_DATA !== 8'hA5) begin failures++; $display("[TB] FAIL good_p_data: got %h expected a5", P_DATA); end
        if (dv_cyc_q.size() > 0) begin
            checks++; if (dv_cyc_q[0] - s != (1 + 8 + 1 + 1) * 8 + 1) begin failures++; $display("[TB] FAIL good_latency: got %0d expected %0d", dv_cyc_q[0] - s, (1 + 8 + 1 + 1) * 8 + 1); end
        end
    endtask

    task automatic test_parity_error();
        int s;
        clear_monitor();
        send_frame(8'h5A, 16, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, s);
        RX_IN = 1'b1;
        repeat (6) @(negedge CLK);
        model_err++;
        checks++; if (pe_cnt != 1) begin failures++; $display("[TB] FAIL parerr_count: got %0d expected 1", pe_cnt); end
        checks++; if (dv_cnt != 0 || se_cnt != 0) begin failures++; $display("[TB] FAIL parerr_others: got dv %0d stp %0d expected 0 0", dv_cnt, se_cnt); end
        checks++; if (P_DATA !== model_data) begin failures++; $display("[TB] FAIL parerr_p_data_held: got %h expected %h", P_DATA, model_data); end
    endtask

    task automatic test_stop_error();
        int s;
        clear_monitor();
        send_frame(8'h3C, 32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, s);
        RX_IN = 1'b1;
        repeat (6) @(negedge CLK);
        model_err++;
        checks++; if (se_cnt != 1) begin failures++; $display("[TB] FAIL stperr_count: got %0d expected 1", se_cnt); end
        checks++; if (dv_cnt != 0 || pe_cnt != 0) begin failures++; $display("[TB] FAIL stperr_others: got dv %0d par %0d expected 0 0", dv_cnt, pe_cnt); end
        checks++; if (P_DATA !== model_data) begin failures++; $display("[TB] FAIL stperr_p_data_held: got %h expected %h", P_DATA, model_data); end
`ifdef UART_RX_ERR_CNT_EN
        checks++; if (err_cnt !== 8'(model_err)) begin failures++; $display("[TB] FAIL stperr_err_cnt: got %0d expected %0d", err_cnt, model_err); end
`endif
        clear_monitor();
        send_frame(8'h81, 32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s);
        RX_IN = 1'b1;
        repeat (6) @(negedge CLK);
        model_data = 8'h81;
        checks++; if (dv_cnt != 1) begin failures++; $display("[TB] FAIL recover_dv_count: got %0d expected 1", dv_cnt); end
        checks++; if (P_DATA !== 8'h81) begin failures++; $display("[TB] FAIL recover_p_data: got %h expected 81", P_DATA); end
    endtask

    task automatic test_glitch();
        clear_monitor();
        Prescale = 6'd8;
        RX_IN    = 1'b0;
        repeat (3) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (24) @(negedge CLK);
        checks++; if (dv_cnt != 0 || pe_cnt != 0 || se_cnt != 0) begin failures++; $display("[TB] FAIL glitch_strobes: got dv %0d par %0d stp %0d expected 0 0 0", dv_cnt, pe_cnt, se_cnt); end
        checks++; if (busy_cnt < 1 || busy_cnt > 8) begin failures++; $display("[TB] FAIL glitch_busy_window: got %0d cycles expected 1..8", busy_cnt); end
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("[TB] FAIL glitch_idle: got rx_busy %b expected 0", rx_busy); end
        checks++; if (P_DATA !== model_data) begin failures++; $display("[TB] FAIL glitch_p_data: got %h expected %h", P_DATA, model_data); end
    endtask

    task automatic test_back_to_back();
        int s0;
        int s1;
        clear_monitor();
        send_frame(8'h00, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s0);
        send_frame(8'hFF, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s1);
        RX_IN = 1'b1;
        repeat (6) @(negedge CLK);
        model_data = 8'hFF;
        checks++; if (dv_cnt != 2) begin failures++; $display("[TB] FAIL b2b_dv_count: got %0d expected 2", dv_cnt); end
        checks++; if (s1 - s0 != 160) begin failures++; $display("[TB] FAIL b2b_drive_spacing: got %0d expected 160", s1 - s0); end
        if (dv_cyc_q.size() >= 2) begin
            checks++; if (dv_cyc_q[1] - dv_cyc_q[0] != 160) begin failures++; $display("[TB] FAIL b2b_strobe_spacing: got %0d expected 160", dv_cyc_q[1] - dv_cyc_q[0]); end
            checks++; if (dv_data_q[0] !== 8'h00 || dv_data_q[1] !== 8'hFF) begin failures++; $display("[TB] FAIL b2b_order: got %h %h expected 00 ff", dv_data_q[0], dv_data_q[1]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int s;
        clear_monitor();
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        repeat (8) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (8) @(negedge CLK);
        RX_IN = 1'b0;
        repeat (3) @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("[TB] FAIL midreset_rx_busy: got %b expected 0", rx_busy); end
        checks++; if (P_DATA !== 8'h00) begin failures++; $display("[TB] FAIL midreset_p_data: got %h expected 00", P_DATA); end
        checks++; if (data_valid !== 1'b0 || par_err !== 1'b0 || stp_err !== 1'b0) begin failures++; $display("[TB] FAIL midreset_strobes: got %b%b%b expected 000", data_valid, par_err, stp_err); end
`ifdef UART_RX_ERR_CNT_EN
        checks++; if (err_cnt !== 8'd0) begin failures++; $display("[TB] FAIL midreset_err_cnt: got %0d expected 0", err_cnt); end
`endif
        model_data = 8'h00;
        model_err  = 0;
        RX_IN      = 1'b1;
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        clear_monitor();
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s);
        RX_IN = 1'b1;
        repeat (6) @(negedge CLK);
        model_data = 8'h55;
        checks++; if (dv_cnt != 1) begin failures++; $display("[TB] FAIL postreset_dv_count: got %0d expected 1", dv_cnt); end
        checks++; if (P_DATA !== 8'h55) begin failures++; $display("[TB] FAIL postreset_p_data: got %h expected 55", P_DATA); end
    endtask

    task automatic test_illegal_prescale();
        int waited;
        Prescale = 6'd0;
        RX_IN    = 1'b0;
        repeat (10) @(negedge CLK);
        RX_IN  = 1'b1;
        waited = 0;
        while (rx_busy !== 1'b0 && waited < 3000) begin
            @(negedge CLK);
            waited++;
        end
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("[TB] FAIL illegal_presc_lockup: got rx_busy %b after %0d cycles expected 0", rx_busy, waited); end
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        model_data = 8'h00;
        model_err  = 0;
        repeat (3) @(negedge CLK);
        checks++; if (P_DATA !== 8'h00 || rx_busy !== 1'b0) begin failures++; $display("[TB] FAIL illegal_presc_recover: got p_data %h busy %b expected 00 0", P_DATA, rx_busy); end
    endtask

    task automatic test_random();
        ev_t        exp_q[$];
        logic [7:0] data;
        int         presc;
        int         gap;
        int         s;
        bit         pen;
        bit         ptyp;
        bit         flip;
        bit         stop_val;
        bit         ok;
        clear_monitor();
        for (int n = 0; n < 30; n++) begin
            data     = 8'($urandom);
            presc    = pick_presc();
            pen      = 1'($urandom_range(0, 1));
            ptyp     = 1'($urandom_range(0, 1));
            flip     = pen && ($urandom_range(0, 3) == 0);
            stop_val = ($urandom_range(0, 3) != 0);
            gap      = $urandom_range(0, 3);
            send_frame(data, presc, pen, ptyp, flip, stop_val, 1'b1, s);
            ok = !flip && stop_val;
            if (ok) model_data = data;
            else if (model_err < 255) model_err++;
            exp_q.push_back('{s + (10 + int'(pen)) * presc + 1, {ok, flip, !stop_val}, model_data});
            if (gap > 0) begin
                RX_IN = 1'b1;
                repeat (gap) @(negedge CLK);
            end
        end
        RX_IN = 1'b1;
        repeat (8) @(negedge CLK);
        checks++; if (act_q.size() != exp_q.size()) begin failures++; $display("[TB] FAIL rand_event_count: got %0d expected %0d", act_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            checks++;
            if (act_q[i].cyc != exp_q[i].cyc || act_q[i].kind !== exp_q[i].kind || act_q[i].data !== exp_q[i].data) begin
                failures++;
                $display("[TB] FAIL rand_frame_%0d: got cyc %0d dv/pe/se %b data %h expected cyc %0d dv/pe/se %b data %h",
                         i, act_q[i].cyc, act_q[i].kind, act_q[i].data, exp_q[i].cyc, exp_q[i].kind, exp_q[i].data);
            end
        end
        checks++; if (P_DATA !== model_data) begin failures++; $display("[TB] FAIL rand_final_p_data: got %h expected %h", P_DATA, model_data); end
`ifdef UART_RX_ERR_CNT_EN
        checks++; if (err_cnt !== 8'(model_err)) begin failures++; $display("[TB] FAIL rand_err_cnt: got %0d expected %0d", err_cnt, model_err); end
`endif
        $display("[TB] random frames done, %0d errored frames in model", model_err);
    endtask

    // Run every scenario in order, then print the summary.
    initial begin
        test_reset();
        test_parity_good();
        test_parity_error();
        test_stop_error();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        test_illegal_prescale();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Receive side of the system UART. Oversamples the serial line RX_IN with a runtime prescale, detects and qualifies the start bit, and deserialises OP_WIDTH data bits LSB-first. It optionally checks a parity bit, checks the stop bit, and presents the parallel word with a one-cycle valid strobe to the register-file/control side. Frame format matches the UART transmitter: start(0), data LSB-first, optional parity, stop(1).

Parameters:
OP_WIDTH, 8, data bits per frame.
PRESCALE_W, 6, width of the Prescale input.

Ports:
CLK  input  1  system clock (oversampling clock).
RST  input  1  asynchronous active-low reset.
RX_IN  input  1  serial line, idle high; already synchronised upstream.
Prescale  input  PRESCALE_W  clock cycles per bit; legal values 8, 16, 32.
PAR_EN  input  1  1 = parity bit present in frame.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
P_DATA  output  OP_WIDTH  received word; held until the next good frame.
data_valid  output  1  one-cycle strobe: P_DATA updated with a good frame.
par_err  output  1  one-cycle strobe: parity mismatch.
stp_err  output  1  one-cycle strobe: stop bit sampled 0.
rx_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (RST=0, asynchronous): FSM to IDLE, counters 0, P_DATA=0, data_valid=par_err=stp_err=rx_busy=0.
- Counters: edge_cnt runs 0..Prescale-1 within each bit period and wraps to 0; bit_cnt counts data bits 0..OP_WIDTH-1.
- Sampling: RX_IN is sampled at edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1. The bit value is the 2-of-3 majority, decided at edge_cnt = Prescale-1.
- Configuration latch: PAR_EN, PAR_TYP and Prescale are captured on the IDLE->START transition and held for the whole frame. Mid-frame changes have no effect.
- FSM transitions, each taken at the edge_cnt = Prescale-1 decision unless stated otherwise:
  - IDLE: RX_IN=0 -> START. The detection cycle counts as edge_cnt 0.
  - START: majority 1 -> glitch, return to IDLE with no strobes. Majority 0 -> DATA.
  - DATA: shift the sampled bit into the shift register LSB-first. After bit OP_WIDTH-1, go to PARITY if the latched PAR_EN=1, else to STOP.
  - PARITY: expected bit = (XOR of the data bits) XOR PAR_TYP. A mismatch sets an internal parity-fail flag. Go to STOP.
  - STOP: evaluate the frame, then return to IDLE.
- End-of-frame outcome, registered and visible the cycle after the stop-bit decision:
  - stop bit 1 and parity OK (or parity disabled): P_DATA <= shift register, data_valid=1 for exactly 1 cycle.
  - otherwise: P_DATA unchanged, data_valid=0; par_err and/or stp_err pulse 1 cycle. Both may pulse together.
- Latency: data_valid rises (1+OP_WIDTH+PAR_EN+1)*Prescale cycles after the first low sample of the start bit, +1 register cycle.
- Back-to-back frames: after STOP the FSM is in IDLE. A low RX_IN on the very next cycle starts a new frame with no dead cycles.
- Line held low after a bad stop bit (break condition): stp_err pulses. The FSM re-enters START, and START re-qualifies the line as a start bit.
- Illegal Prescale values (anything other than 8/16/32): behaviour is undefined, but the FSM must not lock up. A reset always recovers it.

Optional Feature:
UART_RX_ERR_CNT_EN
- Defined: adds output port err_cnt [7:0]. It increments on every frame that pulses par_err or stp_err; one increment per frame even when both strobes pulse. It saturates at 255 and clears only on reset.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Prescale=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 with parity bit 0 -> data_valid 1 cycle, P_DATA=0xA5, par_err=stp_err=0; strobe at 88 cycles +1 after the start edge.
- Prescale=16, PAR_EN=1, PAR_TYP=1, frame 0x5A with parity bit 0 (wrong) -> par_err 1 cycle, data_valid=0, P_DATA keeps its previous value 0xA5.
- Prescale=32, PAR_EN=0, frame 0x3C with stop bit 0 -> stp_err 1 cycle, no data_valid; a following good frame 0x81 -> P_DATA=0x81.
- Prescale=8: RX_IN low for 3 cycles then high (glitch) -> FSM returns to IDLE, no strobes; rx_busy high only during the glitch window.
- Prescale=16: two back-to-back frames 0x00 and 0xFF, parity off, no idle gap -> two data_valid strobes exactly 160 cycles apart, values in order.
- Prescale=8: RST pulled low mid-DATA, then released, then a clean frame 0x55 -> all outputs 0 during reset, then data_valid with P_DATA=0x55 (with UART_RX_ERR_CNT_EN: err_cnt=0 after reset).
